// File: rtl/trisc_sequencer_if.sv
// Control/status bundle between the TRISC sequencer, front panel and datapath.
// The `step` line exists only when TRISC_SINGLE_STEP_EN is defined.
interface trisc_sequencer_if #(parameter int OPW = 4);
    logic           start_stop;
    logic [OPW-1:0] opcode;
    logic           zero_flag;
    logic           neg_flag;
`ifdef TRISC_SINGLE_STEP_EN
    logic           step;
`endif
    logic [14:0]    ctrl;
    logic           running;
    logic           halted;
    logic           illegal;

`ifdef TRISC_SINGLE_STEP_EN
    modport master (output start_stop, opcode, zero_flag, neg_flag, step,
                    input  ctrl, running, halted, illegal);
    modport slave  (input  start_stop, opcode, zero_flag, neg_flag, step,
                    output ctrl, running, halted, illegal);
`else
    modport master (output start_stop, opcode, zero_flag, neg_flag,
                    input  ctrl, running, halted, illegal);
    modport slave  (input  start_stop, opcode, zero_flag, neg_flag,
                    output ctrl, running, halted, illegal);
`endif
endinterface

// File: rtl/trisc_sequencer.sv
// TRISC multi-cycle decode/T-state sequencer driving the 15-bit datapath control word.
// Optional single-step input enabled by defining TRISC_SINGLE_STEP_EN.
module trisc_sequencer #(
    parameter int OPW      = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic             clock,
    input  logic             reset,
    trisc_sequencer_if.slave bus
);
    localparam logic [14:0] C_PC_OUT  = 15'h0001;
    localparam logic [14:0] C_MAR_LD  = 15'h0002;
    localparam logic [14:0] C_MEM_RD  = 15'h0004;
    localparam logic [14:0] C_IR_LD   = 15'h0008;
    localparam logic [14:0] C_PC_INC  = 15'h0010;
    localparam logic [14:0] C_MEM_WR  = 15'h0020;
    localparam logic [14:0] C_ACC_LD  = 15'h0040;
    localparam logic [14:0] C_ACC_OUT = 15'h0080;
    localparam logic [14:0] C_ALU_ADD = 15'h0100;
    localparam logic [14:0] C_ALU_SUB = 15'h0200;
    localparam logic [14:0] C_ALU_XOR = 15'h0400;
    localparam logic [14:0] C_ALU_INC = 15'h0800;
    localparam logic [14:0] C_ACC_CLR = 15'h1000;
    localparam logic [14:0] C_PC_LD   = 15'h2000;
    localparam logic [14:0] C_IR_ADDR = 15'h4000;
    localparam logic [2:0]  WLAST     = 3'(MEM_WAIT);

    typedef enum logic [2:0] {S_IDLE, S_F1, S_F2, S_D, S_E, S_HALT} state_t;

    state_t      state, state_nx;
    logic [2:0]  wcnt;
    logic        ss_q, edge_ss;
    logic        stop_req, stop_req_nx, stop_eff;
    logic        illegal_q, illegal_nx;
    logic        run, wlast, upper_nz, op_ok, to_f1;
    logic [3:0]  op;
    logic [14:0] ctrl_c;

    if (OPW > 4) begin : g_upper
        assign upper_nz = |bus.opcode[OPW-1:4];
    end else begin : g_no_upper
        assign upper_nz = 1'b0;
    end

    assign op      = bus.opcode[3:0];
    assign op_ok   = !upper_nz && (op <= 4'd9 || op == 4'd15);
    assign edge_ss = bus.start_stop & ~ss_q;
    assign run     = (state == S_F1) || (state == S_F2) || (state == S_D) || (state == S_E);
    assign wlast   = (wcnt == WLAST);
    // An edge arriving in the last cycle of an instruction still stops before the next fetch.
    assign stop_eff = stop_req | (edge_ss & run);

`ifdef TRISC_SINGLE_STEP_EN
    logic step_q, step_edge, step_mode, step_mode_nx;
    assign step_edge = bus.step & ~step_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q    <= 1'b1;
            step_mode <= 1'b0;
        end else begin
            step_q    <= bus.step;
            step_mode <= step_mode_nx;
        end
    end
`else
    logic step_mode;
    assign step_mode = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        ctrl_c      = '0;
        stop_req_nx = stop_req | (edge_ss & run);
        illegal_nx  = illegal_q;
        to_f1       = 1'b0;
`ifdef TRISC_SINGLE_STEP_EN
        step_mode_nx = step_mode;
`endif
        case (state)
            S_IDLE: begin
                if (edge_ss) state_nx = S_F1;
`ifdef TRISC_SINGLE_STEP_EN
                else if (step_edge) begin
                    state_nx     = S_F1;
                    step_mode_nx = 1'b1;
                end
`endif
            end
            S_F1: begin
                ctrl_c   = C_PC_OUT | C_MAR_LD;
                state_nx = S_F2;
            end
            S_F2: begin
                ctrl_c = C_MEM_RD;
                if (wlast) begin
                    ctrl_c   = ctrl_c | C_IR_LD | C_PC_INC;
                    state_nx = S_D;
                end
            end
            S_D: begin
                if (!op_ok) begin
                    illegal_nx = 1'b1;
                    to_f1      = 1'b1;
                end else begin
                    case (op)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                            ctrl_c   = C_IR_ADDR | C_MAR_LD;
                            state_nx = S_E;
                        end
                        4'd5: begin ctrl_c = C_ACC_LD | C_ALU_INC; to_f1 = 1'b1; end
                        4'd6: begin ctrl_c = C_ACC_CLR; to_f1 = 1'b1; end
                        4'd7: begin ctrl_c = C_IR_ADDR | C_PC_LD; to_f1 = 1'b1; end
                        4'd8: begin
                            if (bus.zero_flag) ctrl_c = C_IR_ADDR | C_PC_LD;
                            to_f1 = 1'b1;
                        end
                        4'd9: begin
                            if (bus.neg_flag) ctrl_c = C_IR_ADDR | C_PC_LD;
                            to_f1 = 1'b1;
                        end
                        4'd15: begin
                            state_nx = S_HALT;
`ifdef TRISC_SINGLE_STEP_EN
                            step_mode_nx = 1'b0;
`endif
                        end
                        default: to_f1 = 1'b1;
                    endcase
                end
            end
            S_E: begin
                if (op == 4'd1) begin
                    ctrl_c = C_ACC_OUT | C_MEM_WR;
                end else begin
                    ctrl_c = C_MEM_RD;
                    if (wlast) begin
                        case (op)
                            4'd2:    ctrl_c = ctrl_c | C_ACC_LD | C_ALU_ADD;
                            4'd3:    ctrl_c = ctrl_c | C_ACC_LD | C_ALU_SUB;
                            4'd4:    ctrl_c = ctrl_c | C_ACC_LD | C_ALU_XOR;
                            default: ctrl_c = ctrl_c | C_ACC_LD;
                        endcase
                    end
                end
                if (wlast) to_f1 = 1'b1;
            end
            S_HALT: begin
                // A stop already pending when HLT was decoded wins over resume.
                if (edge_ss) begin
                    if (stop_req) begin
                        state_nx    = S_IDLE;
                        stop_req_nx = 1'b0;
                    end else begin
                        state_nx = S_F1;
                    end
                end
`ifdef TRISC_SINGLE_STEP_EN
                else if (step_edge) begin
                    state_nx     = S_F1;
                    step_mode_nx = 1'b1;
                    stop_req_nx  = 1'b0;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase

        if (to_f1) begin
            if (stop_eff || step_mode) begin
                state_nx    = S_IDLE;
                stop_req_nx = 1'b0;
`ifdef TRISC_SINGLE_STEP_EN
                step_mode_nx = 1'b0;
`endif
            end else begin
                state_nx = S_F1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            ss_q      <= 1'b1;
            stop_req  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            ss_q      <= bus.start_stop;
            stop_req  <= stop_req_nx;
            illegal_q <= illegal_nx;
            // Counts within one F2/E stretch; leaving it returns to zero for the next entry.
            wcnt      <= ((state == S_F2 || state == S_E) && !wlast) ? wcnt + 3'd1 : 3'd0;
        end
    end

    assign bus.ctrl    = ctrl_c;
    assign bus.running = run;
    assign bus.halted  = (state == S_HALT);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_trisc_sequencer.sv
// Directed bench for trisc_sequencer: per-cycle expectations queued from an
// instruction-level model, plus literal checks on a MEM_WAIT=0 instance.
module tb_trisc_sequencer;
    localparam int W   = 2;
    localparam int OPW = 5;

    typedef struct {
        logic [14:0] ctrl;
        logic        run;
        logic        hlt;
        logic        ill;
    } exp_t;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic reset0 = 1'b1;
    always #5 clock = ~clock;

    trisc_sequencer_if #(.OPW(OPW)) bus ();
    trisc_sequencer_if #(.OPW(4))   bus0 ();

    trisc_sequencer #(.OPW(OPW), .MEM_WAIT(W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    trisc_sequencer #(.OPW(4), .MEM_WAIT(0)) dut0 (.clock(clock), .reset(reset0), .bus(bus0.slave));

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        ill_m  = 1'b0;
    exp_t        expq[$];
    exp_t        ce;
    logic [14:0] seq[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endfunction

    function automatic logic is_illegal(input int op);
        return !((op >= 0 && op <= 9) || op == 15);
    endfunction

    // Instruction-level model: the ctrl word for every cycle from F1 to the last cycle.
    task automatic build_seq(input int op, input logic zf, input logic nf, input int w);
        seq.delete();
        seq.push_back(15'h0003);
        for (int i = 0; i < w; i++) seq.push_back(15'h0004);
        seq.push_back(15'h001C);
        if (op >= 0 && op <= 4) begin
            seq.push_back(15'h4002);
            if (op == 1) begin
                for (int i = 0; i <= w; i++) seq.push_back(15'h00A0);
            end else begin
                for (int i = 0; i < w; i++) seq.push_back(15'h0004);
                case (op)
                    2:       seq.push_back(15'h0144);
                    3:       seq.push_back(15'h0244);
                    4:       seq.push_back(15'h0444);
                    default: seq.push_back(15'h0044);
                endcase
            end
        end else begin
            case (op)
                5:       seq.push_back(15'h0840);
                6:       seq.push_back(15'h1000);
                7:       seq.push_back(15'h6000);
                8:       seq.push_back(zf ? 15'h6000 : 15'h0000);
                9:       seq.push_back(nf ? 15'h6000 : 15'h0000);
                default: seq.push_back(15'h0000);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [14:0] c, input logic r, input logic h);
        exp_t e;
        e.ctrl = c; e.run = r; e.hlt = h; e.ill = ill_m;
        expq.push_back(e);
    endtask

    task automatic cyc_idle(input logic ss);
        tick();
        bus.start_stop = ss;
        push_exp(15'h0, 1'b0, 1'b0);
    endtask

    task automatic cyc_halt(input logic ss);
        tick();
        bus.start_stop = ss;
        push_exp(15'h0, 1'b0, 1'b1);
    endtask

    task automatic run_instr(input int op, input logic zf = 1'b0, input logic nf = 1'b0,
                             input int ss_at = -1);
        int d_idx;
        d_idx = W + 2;
        build_seq(op, zf, nf, W);
        for (int i = 0; i < seq.size(); i++) begin
            tick();
            bus.opcode     = op[OPW-1:0];
            bus.zero_flag  = zf;
            bus.neg_flag   = nf;
            bus.start_stop = (i == ss_at);
            push_exp(seq[i], 1'b1, 1'b0);
            if (i == d_idx && is_illegal(op)) ill_m = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (expq.size() != 0) begin
            ce = expq.pop_front();
            chk("ctrl",    32'(bus.ctrl),    32'(ce.ctrl));
            chk("running", 32'(bus.running), 32'(ce.run));
            chk("halted",  32'(bus.halted),  32'(ce.hlt));
            chk("illegal", 32'(bus.illegal), 32'(ce.ill));
        end
    end

    initial begin
        bus.start_stop  = 1'b1;
        bus.opcode      = '0;
        bus.zero_flag   = 1'b0;
        bus.neg_flag    = 1'b0;
        bus0.start_stop = 1'b0;
        bus0.opcode     = 4'd2;
        bus0.zero_flag  = 1'b0;
        bus0.neg_flag   = 1'b0;
`ifdef TRISC_SINGLE_STEP_EN
        bus.step  = 1'b0;
        bus0.step = 1'b0;
`endif

        // Hand-computed pins on the model itself.
        build_seq(2, 1'b0, 1'b0, 0);
        chk("model_add_w0_len", 32'(seq.size()), 32'd4);
        chk("model_add_w0_e",   32'(seq[3]), 32'h0144);
        build_seq(1, 1'b0, 1'b0, 2);
        chk("model_sta_w2_len", 32'(seq.size()), 32'd8);
        chk("model_sta_w2_f2",  32'(seq[3]), 32'h001C);
        chk("model_sta_w2_e",   32'(seq[7]), 32'h00A0);

        // MEM_WAIT=0 instance, ADD: literal control sequence.
        tick();
        tick();
        reset0 = 1'b0;
        tick();
        bus0.start_stop = 1'b1;
        @(negedge clock);
        chk("w0_edge_ctrl", 32'(bus0.ctrl), 32'h0);
        chk("w0_edge_run",  32'(bus0.running), 32'h0);
        tick();
        bus0.start_stop = 1'b0;
        @(negedge clock);
        chk("w0_f1",     32'(bus0.ctrl), 32'h0003);
        chk("w0_f1_run", 32'(bus0.running), 32'h1);
        tick(); @(negedge clock); chk("w0_f2", 32'(bus0.ctrl), 32'h001C);
        tick(); @(negedge clock); chk("w0_d",  32'(bus0.ctrl), 32'h4002);
        tick(); @(negedge clock); chk("w0_e",  32'(bus0.ctrl), 32'h0144);
        tick(); @(negedge clock); chk("w0_next_f1", 32'(bus0.ctrl), 32'h0003);

        // Main instance: start_stop held high through reset must not start.
        cyc_idle(1'b1);
        cyc_idle(1'b1);
        reset = 1'b0;
        cyc_idle(1'b1);
        cyc_idle(1'b1);
        cyc_idle(1'b1);
        cyc_idle(1'b0);
        cyc_idle(1'b1);

        run_instr(1);
        run_instr(2);
        run_instr(0);
        run_instr(3);
        run_instr(4);
        run_instr(5);
        run_instr(6);
        run_instr(7);
        run_instr(8, 1'b1, 1'b0);
        run_instr(8, 1'b0, 1'b0);
        run_instr(9, 1'b0, 1'b1);
        run_instr(9, 1'b0, 1'b0);
        run_instr(8, 1'b0, 1'b1);
        run_instr(12);
        run_instr(5);
        run_instr(21);
        run_instr(15);
        cyc_halt(1'b0);
        cyc_halt(1'b0);
        cyc_halt(1'b1);
        run_instr(7);

        // Stop in first E cycle of LDA, then stop during F2 of ADD.
        run_instr(0, 1'b0, 1'b0, W + 3);
        cyc_idle(1'b0);
        cyc_idle(1'b0);
        cyc_idle(1'b1);
        run_instr(2, 1'b0, 1'b0, 1);
        cyc_idle(1'b0);
        cyc_idle(1'b0);
        cyc_idle(1'b1);

        // Edge alongside HLT decode: HALT, then the next edge goes to IDLE.
        run_instr(15, 1'b0, 1'b0, W + 2);
        cyc_halt(1'b0);
        cyc_halt(1'b1);
        cyc_idle(1'b0);
        cyc_idle(1'b0);
        cyc_idle(1'b1);
        run_instr(6);
        run_instr(5);

        // Reset in the middle of a fetch.
        tick();
        push_exp(15'h0003, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        push_exp(15'h0004, 1'b1, 1'b0);
        ill_m = 1'b0;
        tick();
        reset = 1'b0;
        push_exp(15'h0, 1'b0, 1'b0);
        cyc_idle(1'b0);
        cyc_idle(1'b0);

`ifdef TRISC_SINGLE_STEP_EN
        tick();
        bus.step = 1'b1;
        push_exp(15'h0, 1'b0, 1'b0);
        run_instr(5);
        bus.step = 1'b0;
        cyc_idle(1'b0);
        cyc_idle(1'b0);
`endif

        tick();
        tick();
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trisc_sequencer.md
# trisc_sequencer

Parametrised multi-cycle control sequencer for the TRISC accumulator CPU. It combines instruction decode and T-state control into one block. It steps fetch/decode/execute, adds configurable memory wait states, run/stop edge control and HALT resume. It also provides illegal-opcode trapping, and drives the 15-bit control word consumed by the datapath.

## Interface
- OPW, 4: opcode width (≥4); bits above [3:0] must be zero or the opcode is illegal.
- MEM_WAIT, 0: extra memory wait cycles per memory access (0–7).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start_stop  in  OPW-independent 1  run/stop request; rising edge acts.
- opcode  in  OPW  IR opcode field, valid from the cycle after IR_LD.
- zero_flag  in  1  accumulator == 0.
- neg_flag  in  1  accumulator MSB.
- ctrl  out  15  control word: c0 PC_OUT, c1 MAR_LD, c2 MEM_RD, c3 IR_LD, c4 PC_INC, c5 MEM_WR, c6 ACC_LD, c7 ACC_OUT, c8 ALU_ADD, c9 ALU_SUB, c10 ALU_XOR, c11 ALU_INC, c12 ACC_CLR, c13 PC_LD, c14 IR_ADDR_OUT.
- running  out  1  high in F1/F2/D/E.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on illegal opcode decode.

## Operation
- Opcodes: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 XOR, 5 INC, 6 CLR, 7 JMP, 8 JPZ, 9 JPN, 15 HLT. Opcodes 10–14, and any opcode with nonzero upper bits, are illegal.
- States: IDLE, F1, F2, D, E, HALT.
- Edge detect: start_stop_q registers start_stop. Edge = start_stop & ~start_stop_q.
- IDLE: ctrl=0. On edge → F1.
- F1: PC_OUT|MAR_LD → F2.
- F2: MEM_RD for MEM_WAIT+1 cycles via wait counter. The final cycle adds IR_LD|PC_INC, then → D.
- D, memory ops (0–4): IR_ADDR_OUT|MAR_LD → E.
- D, INC: ACC_LD|ALU_INC → F1.
- D, CLR: ACC_CLR → F1.
- D, JMP: IR_ADDR_OUT|PC_LD → F1.
- D, JPZ/JPN: same as JMP if zero_flag/neg_flag is high in the D cycle, else ctrl=0; → F1.
- D, HLT: ctrl=0 → HALT.
- D, illegal: ctrl=0, illegal<=1, executes as NOP → F1.
- E, LDA/ADD/SUB/XOR: MEM_RD for MEM_WAIT+1 cycles. The final cycle adds ACC_LD plus (none, ALU_ADD, ALU_SUB, ALU_XOR) respectively → F1.
- E, STA: ACC_OUT|MEM_WR for MEM_WAIT+1 cycles → F1.
- HALT: ctrl=0. On edge → F1, resuming at the current PC.
- Stop: an edge while running sets stop_req. The current instruction completes. At the transition that would enter F1, go to IDLE instead and clear stop_req.
- ctrl is combinational from state, wait counter, opcode and flags. All other state is registered.

## Timing
- Reset values: state=IDLE, ctrl=0, running=0, halted=0, illegal=0, stop_req=0, wait counter=0, start_stop_q=1. Because start_stop_q resets to 1, an input held high through reset does not start the sequencer.
- Reset mid-instruction: next cycle is IDLE with ctrl=0; no partial completion.
- Cycles per instruction, W=MEM_WAIT:
  - INC/CLR/JMP/JPZ/JPN/illegal: W+3.
  - Memory ops: 2W+4.
  - HLT: W+3 to reach HALT.
- First F1 is the cycle after the edge cycle.
- An edge in the same cycle that D decodes HLT enters HALT and sets stop_req. Leaving HALT then requires a new edge, which goes to IDLE. Stop takes priority over resume.
- The wait counter reloads on every F2/E entry. No wrap beyond MEM_WAIT.

## Configuration
- TRISC_SINGLE_STEP_EN defined: adds input port `step` (1 bit, edge detected, step_q resets to 1). A step edge in IDLE or HALT runs exactly one instruction and then returns to IDLE. HLT run via step goes to HALT. If start_stop and step edges coincide, start_stop wins.
- TRISC_SINGLE_STEP_EN undefined: no `step` port. IDLE/HALT exit only via start_stop.

## Test plan
- Reset hold and start_stop held high across reset release: ctrl=0, running=0, and no start until start_stop goes low then high.
- MEM_WAIT=0, opcode=2 (ADD): ctrl sequence 0x0003, 0x001C, 0x4002, 0x0144, then F1; 4 cycles total.
- MEM_WAIT=2, opcode=1 (STA): F2 MEM_RD for 3 cycles, E ACC_OUT|MEM_WR=0x00A0 for 3 cycles; 8 cycles total.
- JPZ with zero_flag=1 → D ctrl=0x6000; with zero_flag=0 → D ctrl=0; JPN likewise on neg_flag.
- opcode=12 → illegal=1, sticky through the next instructions; opcode=15 → halted=1, ctrl=0; start_stop edge → F1 next cycle.
- Stop edge issued in E of LDA → LDA completes (ACC_LD seen), then IDLE, running=0. With TRISC_SINGLE_STEP_EN, a step edge → exactly one instruction, then IDLE.
